vec_alu_seq: RTL and testbench
==============================

// Module: vec_alu_seq
// PURPOSE
//  Sequencer that executes one vector arithmetic instruction at a time on the 512-bit ALU
//  (ports start/add/mul/A1/A2 in, A3/A4 out). It accepts {op,rd,rs1,rs2} over a valid/ready
//  handshake, reads two operands from the vector register file, and drives the ALU op strobe
//  for ALU_LAT cycles. It then writes the result back: A3 for ADD, A3 and A4 for MUL. It sits
//  between the instruction decode stage and the ALU / vector register file.
// PARAMETERS
//  DATA_W   512  vector width (ALU A1..A4, RF data)
//  REG_AW   5    vector register index width (2**REG_AW registers)
//  ALU_LAT  1    cycles the op strobe is held before A3/A4 are sampled (>=1)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  instr_valid  in   1        instruction offered
//  instr_ready  out  1        sequencer can accept (IDLE only)
//  instr_op     in   2        00=ADD, 01=MUL, 10/11 illegal
//  instr_rd     in   REG_AW   destination register (MUL also writes rd+1)
//  instr_rs1    in   REG_AW   source 1 -> ALU A1
//  instr_rs2    in   REG_AW   source 2 -> ALU A2
//  rf_raddr1    out  REG_AW   RF read address 1
//  rf_raddr2    out  REG_AW   RF read address 2
//  rf_rdata1    in   DATA_W   RF read data 1, valid one cycle after address
//  rf_rdata2    in   DATA_W   RF read data 2, valid one cycle after address
//  rf_we        out  1        RF write enable
//  rf_waddr     out  REG_AW   RF write address
//  rf_wdata     out  DATA_W   RF write data
//  alu_start    out  1        ALU init pulse
//  alu_add      out  1        ALU add strobe
//  alu_mul      out  1        ALU mul strobe
//  alu_a1       out  DATA_W   ALU operand 1
//  alu_a2       out  DATA_W   ALU operand 2
//  alu_a3       in   DATA_W   ALU result low / sum
//  alu_a4       in   DATA_W   ALU result high (MUL)
//  done         out  1        1-cycle pulse: instruction retired
//  err          out  1        1-cycle pulse with done: instruction rejected
// BEHAVIOUR
//  - All outputs are registered. While rst is high: state=INIT and every output is 0.
//  - FSM: INIT -> IDLE -> READ -> LOAD -> EXEC -> WB_LO -> [WB_HI] -> IDLE; also IDLE -> ERR -> IDLE.
//  - INIT: the first cycle after rst deasserts. alu_start=1 for exactly that cycle; instr_ready=0.
//  - IDLE: instr_ready=1. Accept on the edge where instr_valid & instr_ready; latch op, rd, rs1 and rs2.
//  - An illegal op (10/11), or MUL with rd=2**REG_AW-1, goes to ERR.
//    ERR lasts 1 cycle: done=1, err=1, no RF write, no ALU strobe.
//  - READ (1 cycle): rf_raddr1=rs1, rf_raddr2=rs2.
//  - LOAD (1 cycle): rf_rdata1/2 are sampled into alu_a1/alu_a2, which then hold until the next LOAD.
//  - EXEC (ALU_LAT cycles, down-counter): alu_add=op==ADD, alu_mul=op==MUL, never both.
//    alu_a3/alu_a4 are captured into result registers at the end of the last EXEC cycle.
//  - WB_LO: rf_we=1, rf_waddr=rd, rf_wdata=captured A3. For ADD, done=1 in this cycle.
//  - WB_HI (MUL only): rf_we=1, rf_waddr=rd+1, rf_wdata=captured A4, done=1.
//  - Latency from the accept edge to done: ADD = ALU_LAT+3 cycles, MUL = ALU_LAT+4.
//    Throughput is one instruction in flight; instr_ready=0 from READ until back in IDLE.
//  - rd may equal rs1/rs2: operands are latched in LOAD, before any write.
//  - instr_* are ignored outside IDLE. rf_waddr/rf_wdata are don't-care when rf_we=0.
//  - rst asserted mid-instruction aborts it immediately: no write, no done, FSM re-enters INIT.
//  - rf_raddr*, rf_waddr and rd+1 are REG_AW-bit wide; rd+1 never wraps because of the ERR rule.
// TESTING
//  1 Reset release: rst 1->0 -> alu_start high exactly 1 cycle, then instr_ready=1; all other outputs 0.
//  2 ADD rd=3 rs1=1 rs2=2 with R1=R2={1'b1,511'b0}, ALU_LAT=1 ->
//    alu_add high 1 cycle with A1=A2=R1; rf_we once to addr 3 with A3; done at accept+4.
//  3 MUL rd=4 rs1=1 rs2=2 -> alu_mul high 1 cycle; writes addr 4=A3 then addr 5=A4 on consecutive
//    cycles; done with the 2nd write (accept+5).
//  4 Illegal: op=2'b10, then MUL rd=31 -> each gives done&err 1 cycle after accept; no rf_we,
//    no alu_add/alu_mul; instr_ready back 1 the next cycle.
//  5 Back-to-back: instr_valid held high with ADD then MUL queued ->
//    second is accepted only on the first IDLE cycle after done; no overlap of rf_we or strobes.
//  6 rst pulsed during EXEC of a MUL -> no rf_we, no done; INIT alu_start pulse repeats after release.

Source files
------------

// File: rtl/vec_alu_seq_if.sv
// vec_alu_seq_if
//   Bundles the instruction handshake, vector register file ports and ALU
//   ports of the vector ALU sequencer.
//   master : the sequencer (drives instr_ready, RF read/write addresses,
//            RF write data, ALU strobes/operands, done/err)
//   slave  : the environment (decode stage, register file, ALU)
//   Signals:
//     instr_valid/instr_ready/instr_op/instr_rd/instr_rs1/instr_rs2
//     rf_raddr1/rf_raddr2/rf_rdata1/rf_rdata2/rf_we/rf_waddr/rf_wdata
//     alu_start/alu_add/alu_mul/alu_a1/alu_a2/alu_a3/alu_a4
//     done/err
interface vec_alu_seq_if #(
    parameter int DATA_W = 512,
    parameter int REG_AW = 5
);
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        instr_op;
    logic [REG_AW-1:0] instr_rd;
    logic [REG_AW-1:0] instr_rs1;
    logic [REG_AW-1:0] instr_rs2;

    logic [REG_AW-1:0] rf_raddr1;
    logic [REG_AW-1:0] rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic              alu_start;
    logic              alu_add;
    logic              alu_mul;
    logic [DATA_W-1:0] alu_a1;
    logic [DATA_W-1:0] alu_a2;
    logic [DATA_W-1:0] alu_a3;
    logic [DATA_W-1:0] alu_a4;

    logic              done;
    logic              err;

    modport master (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        input  rf_rdata1, rf_rdata2, alu_a3, alu_a4,
        output instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
        output alu_start, alu_add, alu_mul, alu_a1, alu_a2, done, err
    );

    modport slave (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        output rf_rdata1, rf_rdata2, alu_a3, alu_a4,
        input  instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
        input  alu_start, alu_add, alu_mul, alu_a1, alu_a2, done, err
    );
endinterface

// File: rtl/vec_alu_seq.sv
// vec_alu_seq
//   Executes one vector ADD/MUL instruction at a time: accepts {op,rd,rs1,rs2}
//   over valid/ready, reads both operands from the vector register file,
//   strobes the 512-bit ALU for ALU_LAT cycles, then writes A3 (and A4 for
//   MUL, to rd+1) back. Illegal ops and MUL with rd = last register are
//   retired immediately with done+err.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : vec_alu_seq_if.master (instruction, RF and ALU signals)
//   All outputs are registered; every output is 0 while rst is high.
module vec_alu_seq #(
    parameter int DATA_W  = 512,
    parameter int REG_AW  = 5,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    vec_alu_seq_if.master bus
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_READ,
        S_LOAD,
        S_EXEC,
        S_WB_LO,
        S_WB_HI,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_MUL  = 2'b01,
        OP_ILL2 = 2'b10,
        OP_ILL3 = 2'b11
    } op_t;

    generate
        if (ALU_LAT < 1) begin : g_bad_lat
            $error("vec_alu_seq: ALU_LAT must be >= 1");
        end
    endgenerate

    // Control state
    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] res_hi_q, res_hi_d;

    // Output registers
    logic              ready_q, ready_d;
    logic [REG_AW-1:0] raddr1_q, raddr1_d;
    logic [REG_AW-1:0] raddr2_q, raddr2_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              start_q, start_d;
    logic              add_q, add_d;
    logic              mul_q, mul_d;
    logic [DATA_W-1:0] a1_q, a1_d;
    logic [DATA_W-1:0] a2_q, a2_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    op_t  in_op;
    logic in_bad;

    always_comb begin
        in_op  = op_t'(bus.instr_op);
        in_bad = bus.instr_op[1] || ((in_op == OP_MUL) && (bus.instr_rd == '1));
    end

    // Next-state logic. Output registers are loaded with the values that
    // belong to the state being entered, so each output is valid in the
    // same cycle the FSM is in that state.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        ready_d  = 1'b0;
        raddr1_d = raddr1_q;
        raddr2_d = raddr2_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        start_d  = 1'b0;
        add_d    = 1'b0;
        mul_d    = 1'b0;
        a1_d     = a1_q;
        a2_d     = a2_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_INIT: begin
                // INIT spans one full cycle with alu_start high: the first
                // edge after reset raises the pulse, the second leaves INIT.
                if (!start_q) begin
                    start_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end

            S_IDLE: begin
                if (bus.instr_valid && ready_q) begin
                    op_d = in_op;
                    rd_d = bus.instr_rd;
                    if (in_bad) begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = S_READ;
                        raddr1_d = bus.instr_rs1;
                        raddr2_d = bus.instr_rs2;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end

            S_READ: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                a1_d    = bus.rf_rdata1;
                a2_d    = bus.rf_rdata2;
                cnt_d   = CNT_W'(ALU_LAT - 1);
                add_d   = (op_q == OP_ADD);
                mul_d   = (op_q == OP_MUL);
                state_d = S_EXEC;
            end

            S_EXEC: begin
                if (cnt_q == '0) begin
                    // Last EXEC cycle: A3 goes straight into the write-data
                    // register for WB_LO, A4 is parked for WB_HI.
                    res_hi_d = bus.alu_a4;
                    wdata_d  = bus.alu_a3;
                    we_d     = 1'b1;
                    waddr_d  = rd_q;
                    done_d   = (op_q == OP_ADD);
                    state_d  = S_WB_LO;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    add_d = (op_q == OP_ADD);
                    mul_d = (op_q == OP_MUL);
                end
            end

            S_WB_LO: begin
                if (op_q == OP_MUL) begin
                    we_d    = 1'b1;
                    waddr_d = rd_q + REG_AW'(1);
                    wdata_d = res_hi_q;
                    done_d  = 1'b1;
                    state_d = S_WB_HI;
                end else begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_WB_HI, S_ERR: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT;
            op_q     <= OP_ADD;
            rd_q     <= '0;
            cnt_q    <= '0;
            res_hi_q <= '0;
            ready_q  <= 1'b0;
            raddr1_q <= '0;
            raddr2_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            start_q  <= 1'b0;
            add_q    <= 1'b0;
            mul_q    <= 1'b0;
            a1_q     <= '0;
            a2_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            ready_q  <= ready_d;
            raddr1_q <= raddr1_d;
            raddr2_q <= raddr2_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            start_q  <= start_d;
            add_q    <= add_d;
            mul_q    <= mul_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.rf_raddr1   = raddr1_q;
    assign bus.rf_raddr2   = raddr2_q;
    assign bus.rf_we       = we_q;
    assign bus.rf_waddr    = waddr_q;
    assign bus.rf_wdata    = wdata_q;
    assign bus.alu_start   = start_q;
    assign bus.alu_add     = add_q;
    assign bus.alu_mul     = mul_q;
    assign bus.alu_a1      = a1_q;
    assign bus.alu_a2      = a2_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_vec_alu_seq.sv
// tb_vec_alu_seq
//   Bench for vec_alu_seq (ALU_LAT=1). Provides a register file model with
//   one-cycle read latency and a combinational ALU (A1+A2, or the 1024-bit
//   product split into A3/A4). Expected strobes, writes and done/err events
//   are queued when an instruction is accepted and compared as they appear.
module tb_vec_alu_seq;
    localparam int DW = 512;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    vec_alu_seq_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    vec_alu_seq #(.DATA_W(DW), .REG_AW(AW), .ALU_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model
    logic [DW-1:0] rf     [NR];
    logic [DW-1:0] shadow [NR];

    always @(posedge clk) begin
        bus.rf_rdata1 <= rf[bus.rf_raddr1];
        bus.rf_rdata2 <= rf[bus.rf_raddr2];
        if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
    end

    // ALU model
    logic [2*DW-1:0] prod;
    always_comb begin
        prod       = {{DW{1'b0}}, bus.alu_a1} * {{DW{1'b0}}, bus.alu_a2};
        bus.alu_a3 = bus.alu_mul ? prod[DW-1:0] : (bus.alu_a1 + bus.alu_a2);
        bus.alu_a4 = prod[2*DW-1:DW];
    end

    // Scoreboard
    typedef struct { logic mul; logic [DW-1:0] a1; logic [DW-1:0] a2; int cyc; } st_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wr_t;
    typedef struct { logic err; int cyc; } dn_t;

    st_t sq[$];
    wr_t wq[$];
    dn_t dq[$];
    st_t mst;
    wr_t mwr;
    dn_t mdn;

    int checks = 0;
    int errors = 0;
    int last_done = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor
    always @(negedge clk) begin
        if (!rst) begin
            check("strobe_excl", DW'(bus.alu_add & bus.alu_mul), '0);
            if (bus.alu_add || bus.alu_mul) begin
                if (sq.size() == 0) begin
                    check("spurious_strobe", DW'(bus.alu_add | bus.alu_mul), '0);
                end else begin
                    mst = sq.pop_front();
                    check("strobe_mul", DW'(bus.alu_mul), DW'(mst.mul));
                    check("strobe_add", DW'(bus.alu_add), DW'(!mst.mul));
                    check("alu_a1", bus.alu_a1, mst.a1);
                    check("alu_a2", bus.alu_a2, mst.a2);
                    check("strobe_cycle", DW'(cyc), DW'(mst.cyc));
                end
            end
            if (bus.rf_we) begin
                if (wq.size() == 0) begin
                    check("spurious_we", DW'(bus.rf_we), '0);
                end else begin
                    mwr = wq.pop_front();
                    check("wr_addr", DW'(bus.rf_waddr), DW'(mwr.addr));
                    check("wr_data", bus.rf_wdata, mwr.data);
                    check("wr_cycle", DW'(cyc), DW'(mwr.cyc));
                    shadow[mwr.addr] = mwr.data;
                end
            end
            if (bus.done) begin
                if (dq.size() == 0) begin
                    check("spurious_done", DW'(bus.done), '0);
                end else begin
                    mdn = dq.pop_front();
                    check("done_err", DW'(bus.err), DW'(mdn.err));
                    check("done_cycle", DW'(cyc), DW'(mdn.cyc));
                end
            end else begin
                check("err_without_done", DW'(bus.err), '0);
            end
        end
    end

    // Offer an instruction (called at a negedge); returns at the negedge
    // after the accepting edge with instr_valid still high.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input bit b2b);
        bit ok = 1'b0;
        int c;
        logic [DW-1:0]   x, y;
        logic [2*DW-1:0] p;
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs1   = rs1;
        bus.instr_rs2   = rs2;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.instr_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", DW'(bus.instr_ready), DW'(1));
            return;
        end
        c = cyc;
        if (b2b) check("b2b_accept_cycle", DW'(c), DW'(last_done + 1));
        x = shadow[rs1];
        y = shadow[rs2];
        if (op[1] || (op == 2'b01 && rd == AW'(NR - 1))) begin
            dq.push_back('{1'b1, c + 1});
            last_done = c + 1;
        end else if (op == 2'b00) begin
            sq.push_back('{1'b0, x, y, c + 3});
            wq.push_back('{rd, x + y, c + 4});
            dq.push_back('{1'b0, c + 4});
            last_done = c + 4;
        end else begin
            p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
            sq.push_back('{1'b1, x, y, c + 3});
            wq.push_back('{rd, p[DW-1:0], c + 4});
            wq.push_back('{rd + AW'(1), p[2*DW-1:DW], c + 5});
            dq.push_back('{1'b0, c + 5});
            last_done = c + 5;
        end
        @(negedge clk);
    endtask

    task automatic drop();
        bus.instr_valid = 1'b0;
    endtask

    // Wait until all expected events are seen and the DUT is back in IDLE;
    // IDLE must be re-entered the cycle right after done.
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (wq.size() == 0 && dq.size() == 0 && bus.instr_ready) break;
            @(negedge clk);
        end
        check({tag, "_pending"}, DW'(wq.size() + dq.size() + sq.size()), '0);
        check({tag, "_ready_cycle"}, DW'(cyc), DW'(last_done + 1));
    endtask

    // Hold reset, check quiet outputs, release and check the INIT pulse.
    task automatic do_reset();
        rst = 1'b1;
        sq.delete();
        wq.delete();
        dq.delete();
        repeat (2) @(negedge clk);
        check("rst_ctrl", DW'({bus.instr_ready, bus.rf_we, bus.done, bus.err,
                               bus.alu_start, bus.alu_add, bus.alu_mul}), '0);
        check("rst_addr", DW'({bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr}), '0);
        check("rst_a1", bus.alu_a1, '0);
        check("rst_a2", bus.alu_a2, '0);
        check("rst_wdata", bus.rf_wdata, '0);
        rst = 1'b0;
        @(negedge clk);
        check("init_start", DW'(bus.alu_start), DW'(1));
        check("init_ready", DW'(bus.instr_ready), '0);
        @(negedge clk);
        check("init_start_off", DW'(bus.alu_start), '0);
        check("idle_ready", DW'(bus.instr_ready), DW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] topbit;
        bit seen;
        topbit         = '0;
        topbit[DW-1]   = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_op    = '0;
        bus.instr_rd    = '0;
        bus.instr_rs1   = '0;
        bus.instr_rs2   = '0;
        for (int i = 0; i < NR; i++) begin
            rf[i] = {16{$urandom()}};
            rf[i][31:0] = $urandom();
        end
        rf[1] = topbit;
        rf[2] = topbit;
        for (int i = 0; i < NR; i++) shadow[i] = rf[i];

        @(negedge clk);
        do_reset();

        // ADD with carry out of the top bit, then MUL into rd/rd+1
        issue(2'b00, 5'd3, 5'd1, 5'd2, 1'b0); drop(); wait_idle("add");
        issue(2'b01, 5'd4, 5'd1, 5'd2, 1'b0); drop(); wait_idle("mul");

        // Rejected instructions
        issue(2'b10, 5'd5, 5'd1, 5'd2, 1'b0); drop(); wait_idle("ill10");
        issue(2'b01, 5'd31, 5'd1, 5'd2, 1'b0); drop(); wait_idle("mul_rd31");
        issue(2'b11, 5'd0, 5'd3, 5'd4, 1'b0); drop(); wait_idle("ill11");

        // Random operands, rd aliasing a source, highest legal MUL rd
        issue(2'b00, 5'd7, 5'd8, 5'd9, 1'b0); drop(); wait_idle("add_rand");
        issue(2'b01, 5'd10, 5'd10, 5'd11, 1'b0); drop(); wait_idle("mul_alias");
        issue(2'b01, 5'd30, 5'd12, 5'd13, 1'b0); drop(); wait_idle("mul_rd30");
        issue(2'b00, 5'd14, 5'd14, 5'd14, 1'b0); drop(); wait_idle("add_alias");

        // Back-to-back with instr_valid held high
        issue(2'b00, 5'd15, 5'd8, 5'd9, 1'b0);
        issue(2'b01, 5'd16, 5'd10, 5'd12, 1'b1);
        drop(); wait_idle("b2b");

        // Reset during EXEC of a MUL aborts it
        issue(2'b01, 5'd6, 5'd20, 5'd21, 1'b0); drop();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.alu_mul) seen = 1'b1;
            else @(negedge clk);
        end
        check("abort_in_exec", DW'(bus.alu_mul), DW'(1));
        #2;
        do_reset();
        repeat (6) @(negedge clk);
        issue(2'b00, 5'd17, 5'd3, 5'd4, 1'b0); drop(); wait_idle("post_abort");

        for (int i = 0; i < NR; i++) check("rf_final", rf[i], shadow[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
